pipe_reg_skid: RTL and testbench
================================

// Module: pipe_reg_skid
// PURPOSE
//  Parametrised pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
//  Sits between pipeline stages (e.g. IF/ID, ID/EX) and carries WIDTH-bit stage payloads.
//  Provides full throughput (1 transfer/cycle) with no combinational path from out_ready to in_ready.
//  Supports stall by backpressure and flush on branch/exception.
// PARAMETERS
//  WIDTH      16     payload width in bits, >= 1
//  RESET_VAL  '0     value loaded into both data registers on reset and on flush
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      upstream has payload on in_data
//  in_ready   out  1      block can accept a payload this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      out_data holds a valid payload
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  payload to downstream
//  flush      in   1      synchronous discard of all held and incoming payloads
//  occupancy  out  2      number of held payloads, 0..2
// BEHAVIOUR
//  Reset: rst high asynchronously forces state EMPTY, main = skid = RESET_VAL,
//   out_valid = 0, occupancy = 0, in_ready = 0 while rst high; in_ready = 1 first cycle after release.
//  Transfers: accept = in_valid & in_ready; emit = out_valid & out_ready (sampled at rising clk).
//  States (2-bit): EMPTY (occ 0), ONE (main valid, occ 1), FULL (main+skid valid, occ 2).
//  out_valid = (state != EMPTY); out_data = main; in_ready = (state != FULL) & ~rst.
//   All three derive from registers only; no comb path from in_* or out_ready.
//  Transitions (flush = 0):
//   EMPTY: accept -> ONE, main <= in_data; else stay.
//   ONE:   accept & emit -> ONE, main <= in_data; accept & ~emit -> FULL, skid <= in_data;
//          ~accept & emit -> EMPTY; else stay.
//   FULL:  emit -> ONE, main <= skid; else stay (in_ready = 0, no accept possible).
//  Ordering: payloads leave in arrival order; skid is never bypassed.
//  Latency: payload accepted at edge N is presented on out_data after edge N (1 cycle) if
//   block was EMPTY, or when it becomes main otherwise.
//  Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged.
//  Flush (synchronous, highest priority below rst): next state EMPTY, main = skid = RESET_VAL;
//   a payload accepted in the flush cycle is discarded; an emit in the flush cycle still counts
//   as consumed by downstream (downstream sees it this cycle).
//  Unused data registers are not cleared on emit (only on reset/flush); payload value in EMPTY is don't-care.
//  in_valid with in_ready = 0: no change; upstream must hold its payload.
// STRUCTURE
//  Package pipe_pkg: state typedef pipe_state_t {EMPTY=2'd0, ONE=2'd1, FULL=2'd2}; 2'd3 illegal ->
//   treated as EMPTY (recovery on next clk).
//  Sub-module dffen_n #(WIDTH, RESET_VAL): WIDTH-bit flop with enable, async active-high reset;
//   instantiated twice (main, skid). Control FSM and muxes in this module.
// TESTING
//  1 Reset mid-operation: fill to FULL (0x1111,0x2222), assert rst async -> out_valid=0,
//    occupancy=0, out_data=RESET_VAL immediately, in_ready=1 after release.
//  2 Streaming: in_valid=1 every cycle, out_ready=1, data 0x0001..0x0010 -> out_data same
//    sequence, 1 cycle later, occupancy stays 1, in_ready never drops.
//  3 Backpressure: out_ready=0, push 0xAAAA,0xBBBB -> occupancy 2, in_ready=0, out_data=0xAAAA
//    stable; third push 0xCCCC held off; out_ready=1 -> 0xAAAA,0xBBBB,0xCCCC in order.
//  4 Flush: state FULL, flush=1 with in_valid=1 data 0xDEAD -> next cycle occupancy 0,
//    out_valid=0; 0xDEAD never appears on out_data.
//  5 Simultaneous in/out in ONE: main 0x1234, accept 0x5678 with emit -> stays ONE, out_data=0x5678.
//  6 WIDTH=1 and WIDTH=64 builds repeat test 3 with RESET_VAL all-ones -> reset value seen on out_data.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - state encoding and helpers for the skid pipeline register
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_t;

    // The unused encoding 2'd3 behaves exactly like EMPTY and is left on the next edge.
    function automatic pipe_state_t legalize(input pipe_state_t s);
        case (s)
            ONE:     return ONE;
            FULL:    return FULL;
            default: return EMPTY;
        endcase
    endfunction

    function automatic logic [1:0] occ_of(input pipe_state_t s);
        case (s)
            ONE:     return 2'd1;
            FULL:    return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dffen_n.sv
// rtl/dffen_n.sv - WIDTH-bit enabled register with asynchronous reset to RESET_VAL
module dffen_n #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_skid.sv
// rtl/pipe_reg_skid.sv - valid/ready pipeline register with 2-entry skid buffer and flush
module pipe_reg_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy
);

    pipe_state_t      state_q;
    pipe_state_t      state_d;
    pipe_state_t      state_cur;
    logic             accept;
    logic             emit;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Handshake outputs come from registers (plus rst) only, never from out_ready or in_*.
    assign state_cur = legalize(state_q);
    assign out_valid = (state_cur != EMPTY);
    assign in_ready  = (state_cur != FULL) & ~rst;
    assign occupancy = occ_of(state_cur);
    assign out_data  = main_q;

    assign accept = in_valid & in_ready;
    assign emit   = out_valid & out_ready;

    always_comb begin
        state_d = state_cur;
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_data;
        skid_d  = in_data;
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b1;
            skid_en = 1'b1;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_cur)
                ONE: begin
                    if (accept && emit) begin
                        main_en = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        skid_en = 1'b1;
                    end else if (emit) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    // Skid always drains through main so arrival order is preserved.
                    if (emit) begin
                        state_d = ONE;
                        main_en = 1'b1;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    if (accept) begin
                        state_d = ONE;
                        main_en = 1'b1;
                    end
                end
            endcase
        end
    end

    dffen_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    dffen_n #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (skid_d),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb/tb_pipe_reg_skid.sv - self-checking bench for pipe_reg_skid at WIDTH 16, 64 and 1
module tb_pipe_reg_skid;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        flush;
    logic [15:0] in_data16;
    logic [63:0] in_data64;
    logic [0:0]  in_data1;

    logic        in_ready16, in_ready64, in_ready1;
    logic        out_valid16, out_valid64, out_valid1;
    logic [15:0] out_data16;
    logic [63:0] out_data64;
    logic [0:0]  out_data1;
    logic [1:0]  occ16, occ64, occ1;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];
    logic seen_dead = 1'b0;

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        fl;
        int          occ;
        logic        ir;
        logic        ov;
    } vec_t;
    vec_t vecs[16];

    always #5 clk = ~clk;

    function automatic logic [63:0] x64(input logic [15:0] d);
        return {d, ~d, d, 16'h5a5a};
    endfunction

    assign in_data64 = x64(in_data16);
    assign in_data1  = ^in_data16;

    pipe_reg_skid #(.WIDTH(16), .RESET_VAL(16'h0000)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16),
        .flush(flush), .occupancy(occ16)
    );

    pipe_reg_skid #(.WIDTH(64), .RESET_VAL({64{1'b1}})) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .in_data(in_data64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_data(out_data64),
        .flush(flush), .occupancy(occ64)
    );

    pipe_reg_skid #(.WIDTH(1), .RESET_VAL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .flush(flush), .occupancy(occ1)
    );

    always @(negedge clk) begin
        if (!rst && out_valid16 && out_data16 == 16'hDEAD) seen_dead = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, {61'd0, out_valid16, out_valid64, out_valid1}, 64'd0);
        check({tag, "_occ"}, {58'd0, occ16, occ64, occ1}, 64'd0);
        check({tag, "_data16"}, {48'd0, out_data16}, 64'h0);
        check({tag, "_data64"}, out_data64, {64{1'b1}});
        check({tag, "_data1"}, {63'd0, out_data1}, 64'd1);
    endtask

    // Scoreboard step: record handshakes before the edge, compare the registered result after it.
    task automatic step(input string tag);
        logic acc, em;
        #2;
        acc = in_valid & in_ready16;
        em  = out_valid16 & out_ready;
        if (em) begin
            if (sb.size() == 0) begin
                check({tag, "_emit_unexpected"}, {63'd0, em}, 64'd0);
            end else begin
                check({tag, "_emit16"}, {48'd0, out_data16}, {48'd0, sb[0]});
                check({tag, "_emit64"}, out_data64, x64(sb[0]));
                check({tag, "_emit1"}, {63'd0, out_data1}, {63'd0, ^sb[0]});
                void'(sb.pop_front());
            end
        end
        if (flush) sb.delete();
        else if (acc) sb.push_back(in_data16);
        @(posedge clk);
        #1;
        check({tag, "_occ"}, {62'd0, occ16}, sb.size());
        check({tag, "_occ_w"}, {60'd0, occ64, occ1}, {60'd0, occ16, occ16});
        check({tag, "_out_valid"}, {63'd0, out_valid16}, {63'd0, sb.size() != 0});
        check({tag, "_in_ready"}, {61'd0, in_ready16, in_ready64, in_ready1},
              (sb.size() != 2) ? 64'd7 : 64'd0);
        if (sb.size() != 0) begin
            check({tag, "_head16"}, {48'd0, out_data16}, {48'd0, sb[0]});
            check({tag, "_head64"}, out_data64, x64(sb[0]));
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data16 = '0;
        #3;
        check("rst_in_ready", {61'd0, in_ready16, in_ready64, in_ready1}, 64'd0);
        check_reset_outputs("rst");
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("rel_in_ready", {61'd0, in_ready16, in_ready64, in_ready1}, 64'd7);
        check("rel_out_valid", {63'd0, out_valid16}, 64'd0);

        // streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1; in_data16 = 16'(i);
            step($sformatf("stream%0d", i));
        end
        in_valid = 1'b0;
        step("stream_drain");

        // asynchronous reset while FULL
        out_ready = 1'b0; in_valid = 1'b1;
        in_data16 = 16'h1111; step("fill1");
        in_data16 = 16'h2222; step("fill2");
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("midrst_in_ready", {63'd0, in_ready16}, 64'd0);
        check_reset_outputs("midrst");
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("midrel_in_ready", {61'd0, in_ready16, in_ready64, in_ready1}, 64'd7);
        check_reset_outputs("midrel");

        //            iv    data      ordy  fl    occ ir    ov
        vecs[0]  = '{1'b1, 16'hAAAA, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 16'hBBBB, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 16'hCCCC, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 16'hCCCC, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vecs[4]  = '{1'b1, 16'hCCCC, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 16'h5678, 1'b1, 1'b0, 1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 16'h1111, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 16'h2222, 1'b0, 1'b0, 2, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 16'hDEAD, 1'b0, 1'b1, 0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 16'h3333, 1'b0, 1'b0, 1, 1'b1, 1'b1};
        vecs[14] = '{1'b1, 16'h4444, 1'b1, 1'b1, 0, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b0};

        for (int i = 0; i < 16; i++) begin
            in_valid = vecs[i].iv; in_data16 = vecs[i].id;
            out_ready = vecs[i].ordy; flush = vecs[i].fl;
            step($sformatf("vec%0d", i));
            check($sformatf("vec%0d_tab_occ", i), {62'd0, occ16}, vecs[i].occ);
            check($sformatf("vec%0d_tab_ir", i), {63'd0, in_ready16}, {63'd0, vecs[i].ir});
            check($sformatf("vec%0d_tab_ov", i), {63'd0, out_valid16}, {63'd0, vecs[i].ov});
            if (i == 7) check("one_simul_data", {48'd0, out_data16}, 64'h5678);
        end
        flush = 1'b0; in_valid = 1'b0;
        check_reset_outputs("post_flush");

        // backpressure again on all widths with a held third push
        out_ready = 1'b0; in_valid = 1'b1;
        in_data16 = 16'hA5C3; step("bp1");
        in_data16 = 16'h0F0E; step("bp2");
        in_data16 = 16'h7E81; step("bp3_held");
        step("bp4_held");
        out_ready = 1'b1; step("bp5");
        in_valid = 1'b0; step("bp6");
        step("bp7");
        check("bp_drained", sb.size(), 64'd0);
        check("dead_never_out", {63'd0, seen_dead}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
